// File: rtl/microsequencer_pkg.sv
// ---------------------------------------------------------------------------
// microseq_pkg
// Shared definitions for the microsequencer: next-state mode and condition
// select encodings, the default state width, and the opcode -> microstore
// entry table used by opcode_encoder.
// No ports (package).
// ---------------------------------------------------------------------------
package microseq_pkg;

    localparam int STATE_W_DEF = 7;

    // Next-state mode field of the microword
    typedef enum logic [2:0] {
        DECODE    = 3'd0,
        RESTART   = 3'd1,
        JUMP      = 3'd2,
        INCR      = 3'd3,
        BR_INCR   = 3'd4,
        BR_DECODE = 3'd5,
        WAIT_MOC  = 3'd6,
        HALT      = 3'd7
    } ns_mode_e;

    // Condition select field of the microword
    typedef enum logic [1:0] {
        COND_ZERO  = 2'd0,
        COND_NEG   = 2'd1,
        COND_CARRY = 2'd2,
        COND_TRUE  = 2'd3
    } cond_sel_e;

    // Decoded opcodes
    localparam logic [5:0] OP_00 = 6'h00;
    localparam logic [5:0] OP_08 = 6'h08;
    localparam logic [5:0] OP_0F = 6'h0F;
    localparam logic [5:0] OP_23 = 6'h23;
    localparam logic [5:0] OP_2B = 6'h2B;
    localparam logic [5:0] OP_04 = 6'h04;
    localparam logic [5:0] OP_02 = 6'h02;

    // Opcode -> microstore entry. Returns -1 for opcodes with no routine;
    // the encoder maps those to the reset state.
    function automatic int op_target(input logic [5:0] op);
        case (op)
            OP_00:   return 2;
            OP_08:   return 3;
            OP_0F:   return 4;
            OP_23:   return 7;
            OP_2B:   return 13;
            OP_04:   return 11;
            OP_02:   return 6;
            default: return -1;
        endcase
    endfunction

endpackage

// File: rtl/microsequencer_opcode_encoder.sv
// ---------------------------------------------------------------------------
// opcode_encoder
// Combinational map from the IR opcode to the first microstore state of the
// matching routine. Unmapped opcodes go to RESET_STATE.
// Ports:
//   i_opcode  in  6        instruction opcode
//   o_target  out STATE_W  decoded microstore state
// ---------------------------------------------------------------------------
module opcode_encoder
    import microseq_pkg::*;
#(
    parameter int STATE_W     = STATE_W_DEF,
    parameter int RESET_STATE = 0
) (
    input  logic [5:0]         i_opcode,
    output logic [STATE_W-1:0] o_target
);

    int w_tgt;

    always_comb begin
        w_tgt = op_target(i_opcode);
        if (w_tgt < 0) begin
            o_target = STATE_W'(RESET_STATE);
        end else begin
            o_target = STATE_W'(w_tgt);
        end
    end

endmodule

// File: rtl/microsequencer.sv
// ---------------------------------------------------------------------------
// microsequencer
// Next-state controller of the microprogrammed control unit. Holds the
// current microstore address and picks the next one each cycle from the
// microword (mode, condition select/invert, literal target), the opcode
// decode, the ALU flags and memory-operation-complete.
//
// Optional feature: define MICROSEQUENCER_MOC_TIMEOUT_EN to add a wait
// counter on WAIT_MOC that jumps to EXC_STATE and sets mem_timeout after
// TIMEOUT_CYCLES cycles without moc. Undefined: WAIT_MOC holds forever and
// mem_timeout is tied 0.
//
// Ports:
//   clk          in   1        clock, rising edge
//   reset        in   1        synchronous reset, active low
//   ns_mode      in   3        next-state mode field
//   cond_sel     in   2        0=zero 1=negative 2=carry 3=cond_true
//   cond_inv     in   1        invert selected condition
//   cr           in   STATE_W  literal target state
//   opcode       in   6        IR opcode
//   zero, negative, carry in 1 ALU flags
//   cond_true    in   1        branch-condition tester result
//   moc          in   1        memory operation complete
//   state        out  STATE_W  current state (microstore address)
//   halted       out  1        sticky halt flag
//   mem_timeout  out  1        sticky MOC timeout flag
// ---------------------------------------------------------------------------
module microsequencer
    import microseq_pkg::*;
#(
    parameter int STATE_W        = STATE_W_DEF,
    parameter int RESET_STATE    = 0,
    parameter int FETCH_STATE    = 1,
    parameter int MAX_STATE      = 16,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int EXC_STATE      = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         ns_mode,
    input  logic [1:0]         cond_sel,
    input  logic               cond_inv,
    input  logic [STATE_W-1:0] cr,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               negative,
    input  logic               carry,
    input  logic               cond_true,
    input  logic               moc,
    output logic [STATE_W-1:0] state,
    output logic               halted,
    output logic               mem_timeout
);

    localparam logic [STATE_W-1:0] RST_S   = STATE_W'(RESET_STATE);
    localparam logic [STATE_W-1:0] FETCH_S = STATE_W'(FETCH_STATE);
    localparam logic [STATE_W-1:0] MAX_S   = STATE_W'(MAX_STATE);

    logic [STATE_W-1:0] r_state;
    logic               r_halted;
    logic [STATE_W-1:0] w_state_nxt;
    logic               w_halted_nxt;
    logic [STATE_W-1:0] w_enc_state;
    logic [STATE_W-1:0] w_incr;
    logic               w_cond;
    logic               w_flag;

`ifdef MICROSEQUENCER_MOC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [STATE_W-1:0] EXC_S = STATE_W'(EXC_STATE);

    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_mem_timeout;
    logic             w_timeout_nxt;
`else
    // Timeout parameters have no function without the feature.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{TIMEOUT_CYCLES[0], EXC_STATE[0]};
`endif

    opcode_encoder #(
        .STATE_W    (STATE_W),
        .RESET_STATE(RESET_STATE)
    ) u_encoder (
        .i_opcode(opcode),
        .o_target(w_enc_state)
    );

    // Natural STATE_W-bit wrap gives 127 -> 0.
    assign w_incr = r_state + 1'b1;

    always_comb begin
        w_flag = zero;
        case (cond_sel_e'(cond_sel))
            COND_ZERO:  w_flag = zero;
            COND_NEG:   w_flag = negative;
            COND_CARRY: w_flag = carry;
            COND_TRUE:  w_flag = cond_true;
            default:    w_flag = zero;
        endcase
        w_cond = w_flag ^ cond_inv;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_halted_nxt = r_halted;
`ifdef MICROSEQUENCER_MOC_TIMEOUT_EN
        w_cnt_nxt     = '0;
        w_timeout_nxt = r_mem_timeout;
`endif
        if (r_halted) begin
            // Frozen until reset; every input is ignored.
            w_state_nxt = r_state;
        end else if (r_state > MAX_S) begin
            // Unprogrammed addresses fall back the same way the microstore
            // decodes them.
            w_state_nxt = RST_S;
        end else begin
            case (ns_mode_e'(ns_mode))
                DECODE:    w_state_nxt = w_enc_state;
                RESTART:   w_state_nxt = FETCH_S;
                JUMP:      w_state_nxt = cr;
                INCR:      w_state_nxt = w_incr;
                BR_INCR:   w_state_nxt = w_cond ? cr : w_incr;
                BR_DECODE: w_state_nxt = w_cond ? cr : w_enc_state;
                WAIT_MOC: begin
                    if (moc) begin
                        // moc beats a simultaneous timeout
                        w_state_nxt = w_incr;
`ifdef MICROSEQUENCER_MOC_TIMEOUT_EN
                    end else if (r_wait_cnt == CNT_LIM) begin
                        w_state_nxt   = EXC_S;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_state_nxt = r_state;
                        w_cnt_nxt   = r_wait_cnt + 1'b1;
`else
                    end else begin
                        w_state_nxt = r_state;
`endif
                    end
                end
                HALT: begin
                    w_state_nxt  = r_state;
                    w_halted_nxt = 1'b1;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= RST_S;
            r_halted <= 1'b0;
`ifdef MICROSEQUENCER_MOC_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_halted <= w_halted_nxt;
`ifdef MICROSEQUENCER_MOC_TIMEOUT_EN
            r_wait_cnt    <= w_cnt_nxt;
            r_mem_timeout <= w_timeout_nxt;
`endif
        end
    end

    assign state  = r_state;
    assign halted = r_halted;
`ifdef MICROSEQUENCER_MOC_TIMEOUT_EN
    assign mem_timeout = r_mem_timeout;
`else
    assign mem_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_microsequencer.sv
// ---------------------------------------------------------------------------
// tb_microsequencer
// Directed bench for microsequencer. Inputs change 1 ns after each rising
// edge, outputs are sampled at the same point. Built with TIMEOUT_CYCLES=8.
// ---------------------------------------------------------------------------
module tb_microsequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] ns_mode;
    logic [1:0] cond_sel;
    logic       cond_inv;
    logic [6:0] cr;
    logic [5:0] opcode;
    logic       zero, negative, carry, cond_true, moc;
    logic [6:0] state;
    logic       halted, mem_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    microsequencer #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ns_mode    (ns_mode),
        .cond_sel   (cond_sel),
        .cond_inv   (cond_inv),
        .cr         (cr),
        .opcode     (opcode),
        .zero       (zero),
        .negative   (negative),
        .carry      (carry),
        .cond_true  (cond_true),
        .moc        (moc),
        .state      (state),
        .halted     (halted),
        .mem_timeout(mem_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to a given state with a JUMP microword (from a valid state).
    task automatic goto(input logic [6:0] s);
        ns_mode = 3'd2;
        cr      = s;
        tick();
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        ns_mode = 3'd3;
        tick();
        tick();
        n_tests++;
        if (state !== 7'd0 || halted !== 1'b0 || mem_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: state=%0d halted=%b mem_timeout=%b, expected 0/0/0",
                     state, halted, mem_timeout);
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if (state !== 7'd1) begin
            n_fail++;
            $display("FAIL incr_1: state=%0d expected 1", state);
        end
        tick();
        n_tests++;
        if (state !== 7'd2) begin
            n_fail++;
            $display("FAIL incr_2: state=%0d expected 2", state);
        end
    endtask

    task automatic test_decode();
        logic [5:0] ops [8];
        logic [6:0] exp [8];
        ops = '{6'h00, 6'h08, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
        exp = '{7'd2,  7'd3,  7'd4,  7'd7,  7'd13, 7'd11, 7'd6,  7'd0};
        for (int i = 0; i < 8; i++) begin
            goto(7'd1);
            ns_mode = 3'd0;
            opcode  = ops[i];
            tick();
            n_tests++;
            if (state !== exp[i]) begin
                n_fail++;
                $display("FAIL decode op=%h: state=%0d expected %0d", ops[i], state, exp[i]);
            end
        end
    endtask

    task automatic test_branch();
        // BR_INCR, zero true, not inverted -> take
        goto(7'd5);
        ns_mode = 3'd4; cond_sel = 2'd0; zero = 1'b1; cond_inv = 1'b0; cr = 7'd12;
        tick();
        n_tests++;
        if (state !== 7'd12) begin
            n_fail++;
            $display("FAIL br_incr_taken: state=%0d expected 12", state);
        end
        // inverted -> fall through to increment
        goto(7'd5);
        ns_mode = 3'd4; cond_inv = 1'b1; cr = 7'd12;
        tick();
        n_tests++;
        if (state !== 7'd6) begin
            n_fail++;
            $display("FAIL br_incr_inv: state=%0d expected 6", state);
        end
        // BR_DECODE, condition false -> decode 0x2B
        goto(7'd5);
        ns_mode = 3'd5; cond_inv = 1'b1; cr = 7'd12; opcode = 6'h2B;
        tick();
        n_tests++;
        if (state !== 7'd13) begin
            n_fail++;
            $display("FAIL br_decode_false: state=%0d expected 13", state);
        end
        // negative selected, other flags clear -> take
        goto(7'd5);
        ns_mode = 3'd4; cond_sel = 2'd1; cond_inv = 1'b0; zero = 1'b0;
        negative = 1'b1; carry = 1'b0; cond_true = 1'b0; cr = 7'd9;
        tick();
        n_tests++;
        if (state !== 7'd9) begin
            n_fail++;
            $display("FAIL br_negative: state=%0d expected 9", state);
        end
        // carry selected, other flags clear -> take
        goto(7'd5);
        ns_mode = 3'd4; cond_sel = 2'd2; negative = 1'b0; carry = 1'b1; cr = 7'd14;
        tick();
        n_tests++;
        if (state !== 7'd14) begin
            n_fail++;
            $display("FAIL br_carry: state=%0d expected 14", state);
        end
        // cond_true selected but low while other flags set -> not taken
        goto(7'd5);
        ns_mode = 3'd5; cond_sel = 2'd3; zero = 1'b1; negative = 1'b1;
        carry = 1'b1; cond_true = 1'b0; cr = 7'd15; opcode = 6'h08;
        tick();
        n_tests++;
        if (state !== 7'd3) begin
            n_fail++;
            $display("FAIL br_cond_true_low: state=%0d expected 3", state);
        end
        // cond_true high -> BR_DECODE takes cr
        goto(7'd5);
        ns_mode = 3'd5; cond_true = 1'b1; cr = 7'd15;
        tick();
        n_tests++;
        if (state !== 7'd15) begin
            n_fail++;
            $display("FAIL br_decode_taken: state=%0d expected 15", state);
        end
        zero = 1'b0; negative = 1'b0; carry = 1'b0; cond_true = 1'b0;
        cond_sel = 2'd0; cond_inv = 1'b0;
        // RESTART
        ns_mode = 3'd1;
        tick();
        n_tests++;
        if (state !== 7'd1) begin
            n_fail++;
            $display("FAIL restart: state=%0d expected 1", state);
        end
    endtask

    task automatic test_wait();
        goto(7'd9);
        ns_mode = 3'd6; moc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (state !== 7'd9) begin
                n_fail++;
                $display("FAIL wait_hold_%0d: state=%0d expected 9", i, state);
            end
        end
        moc = 1'b1;
        tick();
        n_tests++;
        if (state !== 7'd10) begin
            n_fail++;
            $display("FAIL wait_moc: state=%0d expected 10", state);
        end
        moc = 1'b0;
    endtask

    task automatic test_halt();
        goto(7'd16);
        ns_mode = 3'd7;
        tick();
        n_tests++;
        if (state !== 7'd16 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_enter: state=%0d halted=%b expected 16/1", state, halted);
        end
        ns_mode = 3'd3; cr = 7'd3; moc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (state !== 7'd16 || halted !== 1'b1) begin
                n_fail++;
                $display("FAIL halt_hold_%0d: state=%0d halted=%b expected 16/1", i, state, halted);
            end
        end
        moc   = 1'b0;
        reset = 1'b0;
        tick();
        n_tests++;
        if (state !== 7'd0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_reset: state=%0d halted=%b expected 0/0", state, halted);
        end
        reset = 1'b1;
    endtask

    task automatic test_invalid();
        goto(7'd16);
        ns_mode = 3'd3;
        tick();
        n_tests++;
        if (state !== 7'd17) begin
            n_fail++;
            $display("FAIL incr_past_max: state=%0d expected 17", state);
        end
        // 17 is above the programmed range: any mode goes back to reset state
        ns_mode = 3'd2; cr = 7'd5;
        tick();
        n_tests++;
        if (state !== 7'd0) begin
            n_fail++;
            $display("FAIL invalid_jump: state=%0d expected 0", state);
        end
        goto(7'd100);
        ns_mode = 3'd6; moc = 1'b0;
        tick();
        n_tests++;
        if (state !== 7'd0) begin
            n_fail++;
            $display("FAIL invalid_wait: state=%0d expected 0", state);
        end
    endtask

    task automatic test_reset_mid_wait();
        goto(7'd9);
        ns_mode = 3'd6; moc = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        tick();
        n_tests++;
        if (state !== 7'd0 || mem_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: state=%0d mem_timeout=%b expected 0/0", state, mem_timeout);
        end
        reset = 1'b1;
`ifdef MICROSEQUENCER_MOC_TIMEOUT_EN
        // A cleared counter needs the full 8 holds again before timing out.
        for (int i = 0; i < 8; i++) tick();
        n_tests++;
        if (mem_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL cnt_cleared_by_reset: mem_timeout=%b expected 0", mem_timeout);
        end
        tick();
        n_tests++;
        if (mem_timeout !== 1'b1 || state !== 7'd0) begin
            n_fail++;
            $display("FAIL timeout_after_reset: state=%0d mem_timeout=%b expected 0/1", state, mem_timeout);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
`else
        for (int i = 0; i < 10; i++) tick();
        n_tests++;
        if (state !== 7'd0 || mem_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_after_reset: state=%0d mem_timeout=%b expected 0/0", state, mem_timeout);
        end
`endif
        ns_mode = 3'd3;
    endtask

    task automatic test_timeout();
`ifdef MICROSEQUENCER_MOC_TIMEOUT_EN
        goto(7'd9);
        ns_mode = 3'd6; moc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tests++;
            if (state !== 7'd9 || mem_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL to_hold_%0d: state=%0d mem_timeout=%b expected 9/0", i, state, mem_timeout);
            end
        end
        tick();
        n_tests++;
        if (state !== 7'd0 || mem_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL to_fire: state=%0d mem_timeout=%b expected 0/1", state, mem_timeout);
        end
        ns_mode = 3'd3;
        tick();
        n_tests++;
        if (state !== 7'd1 || mem_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL to_sticky: state=%0d mem_timeout=%b expected 1/1", state, mem_timeout);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        // moc arriving exactly at the limit wins
        goto(7'd9);
        ns_mode = 3'd6; moc = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        moc = 1'b1;
        tick();
        n_tests++;
        if (state !== 7'd10 || mem_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_moc_wins: state=%0d mem_timeout=%b expected 10/0", state, mem_timeout);
        end
        moc = 1'b0;
`else
        goto(7'd9);
        ns_mode = 3'd6; moc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_tests++;
            if (state !== 7'd9 || mem_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL no_to_hold_%0d: state=%0d mem_timeout=%b expected 9/0", i, state, mem_timeout);
            end
        end
        moc = 1'b1;
        tick();
        n_tests++;
        if (state !== 7'd10) begin
            n_fail++;
            $display("FAIL no_to_release: state=%0d expected 10", state);
        end
        moc = 1'b0;
`endif
    endtask

    initial begin
        reset = 1'b0; ns_mode = 3'd0; cond_sel = 2'd0; cond_inv = 1'b0;
        cr = 7'd0; opcode = 6'h00; zero = 1'b0; negative = 1'b0;
        carry = 1'b0; cond_true = 1'b0; moc = 1'b0;
        #2;
        test_reset();
        test_decode();
        test_branch();
        test_wait();
        test_halt();
        test_invalid();
        test_reset_mid_wait();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Next-state controller for the microprogrammed control unit.
- Registers the 7-bit current state that addresses the microstore.
- Each cycle it selects the next state from microword fields: next-state mode, condition select, invert and literal target. The sources are increment, literal jump, opcode decode, conditional branch, memory-complete wait and halt.
- Sits between the microstore outputs and its state input, closing the control loop.

Parameters:
- STATE_W, 7, width of the state register/microstore address.
- RESET_STATE, 0, state loaded on reset.
- FETCH_STATE, 1, target of restart mode.
- MAX_STATE, 16, highest programmed state; any state above it is treated as invalid.
- TIMEOUT_CYCLES, 16, MOC wait limit (used only with the optional feature).
- EXC_STATE, 0, state entered on MOC timeout.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- ns_mode  in  3  next-state mode field from microword.
- cond_sel  in  2  condition select: 0=zero, 1=negative, 2=carry, 3=cond_true.
- cond_inv  in  1  invert selected condition.
- cr  in  STATE_W  literal target state from microword.
- opcode  in  6  instruction opcode from IR.
- zero, negative, carry  in  1 each  ALU flags.
- cond_true  in  1  branch-condition tester result.
- moc  in  1  memory operation complete.
- state  out  STATE_W  current state, drives microstore address.
- halted  out  1  sticky, set by halt mode.
- mem_timeout  out  1  sticky MOC timeout flag (tied 0 without feature).

Behaviour:
- Reset (reset==0 at posedge):
  - state=RESET_STATE, halted=0, mem_timeout=0, wait counter=0.
  - Reset overrides every mode, including mid-wait and halted.
- Latency: next state is computed combinationally from the current inputs and registered on the next posedge; one microinstruction per cycle.
- cond = selected flag XOR cond_inv.
- ns_mode decode:
  - 0 DECODE: state = encoder(opcode).
  - 1 RESTART: state = FETCH_STATE.
  - 2 JUMP: state = cr.
  - 3 INCR: state = state+1, modulo 2^STATE_W (127 wraps to 0).
  - 4 BR_INCR: cond ? cr : state+1.
  - 5 BR_DECODE: cond ? cr : encoder(opcode).
  - 6 WAIT_MOC: moc ? state+1 : state (hold). The wait counter increments while holding and clears when moc=1 or the mode is not 6.
  - 7 HALT: state holds and halted=1; remains until reset. While halted, all inputs are ignored.
- Invalid state:
  - If the registered state exceeds MAX_STATE, the next state is RESET_STATE regardless of mode.
  - This matches the microstore's default decoding to state 0.
- Encoder is combinational, from the package table:
  - 0x00→2, 0x08→3, 0x0F→4, 0x23→7, 0x2B→13, 0x04→11, 0x02→6.
  - Any other opcode → RESET_STATE.
- Simultaneous events:
  - moc=1 in the same cycle the counter reaches its limit: moc wins (advance, no timeout).
  - The condition is sampled only in modes 4/5.

Optional Feature:
- Macro: MICROSEQUENCER_MOC_TIMEOUT_EN.
- Defined:
  - In WAIT_MOC, when the wait counter reaches TIMEOUT_CYCLES with moc=0, next state = EXC_STATE and mem_timeout=1 (sticky until reset).
  - The counter then clears.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- Undefined:
  - No counter is synthesised, WAIT_MOC holds indefinitely, and mem_timeout is tied 0.

Decomposition:
- Package microseq_pkg holds:
  - ns_mode enum (DECODE, RESTART, JUMP, INCR, BR_INCR, BR_DECODE, WAIT_MOC, HALT).
  - cond_sel enum.
  - Opcode constants and the opcode→state table.
  - The STATE_W default.
- Sub-module opcode_encoder (combinational opcode→state) is natural, since the microstore-side decode table changes independently of the sequencing logic.

Test Plan:
- Reset and increment: reset=0 two cycles → state=0, halted=0. Release with ns_mode=3 → state 1, then 2 on successive posedges.
- Decode: state=1, ns_mode=0, opcode=0x23 → state=7 next cycle. opcode=0x3F → state=0.
- Conditional branch:
  - ns_mode=4, cond_sel=0, zero=1, cond_inv=0, cr=12 from state 5 → 12.
  - Same with cond_inv=1 → 6.
  - ns_mode=5, cond false, opcode=0x2B → 13.
- Memory wait: state 9, ns_mode=6, moc=0 for 3 cycles → state stays 9. moc=1 → 10.
- Halt and reset override:
  - ns_mode=7 at state 16 → state 16, halted=1 for 5 cycles with ns_mode changed to 3.
  - reset=0 → state 0, halted=0.
  - Reset asserted mid-WAIT_MOC clears the counter.
- Timeout (with MICROSEQUENCER_MOC_TIMEOUT_EN, TIMEOUT_CYCLES=8): state 9, ns_mode=6, moc=0 held → after 8 wait cycles state=EXC_STATE (0), mem_timeout=1.
- Timeout disabled: with the macro undefined, the same stimulus holds state 9 for 20 cycles and mem_timeout stays 0.
